// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battleship_pkg
// Brief    : Shared state, winner and player codes for the battleship
//            game controller, plus the ship-count clamp helper.
// Revision : 1.0
// ============================================================================
package battleship_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SET_AMOUNT = 3'd1,
        PLACE_P1   = 3'd2,
        PLACE_P2   = 3'd3,
        TURN_P1    = 3'd4,
        TURN_P2    = 3'd5,
        GAME_OVER  = 3'd6
    } state_t;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;

    localparam logic c_PLAYER_P1 = 1'b0;
    localparam logic c_PLAYER_P2 = 1'b1;

    localparam int c_DEFAULT_MAX_SHIPS = 5;

    // Zero ships is not a playable game, so the floor is one.
    function automatic logic [2:0] clamp_ships(input logic [2:0] req,
                                               input logic [2:0] max_ships);
        logic [2:0] result;
        if (req == 3'd0) begin
            result = 3'd1;
        end else if (req > max_ships) begin
            result = max_ships;
        end else begin
            result = req;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/battleship_game_ctrl_btn_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge_detect
// Brief    : Rising-edge detector for a level input. A level already high
//            when reset releases never produces an event.
// Revision : 1.0
// ============================================================================
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic r_prev;
    logic r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= btn;
            r_armed <= 1'b1;
        end
    end

    assign rise = r_armed & btn & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/battleship_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : battleship_game_ctrl
// Brief    : Two-player battleship game flow controller (setup, placement,
//            alternating turns, game over). Define TURN_TIMEOUT_EN to add a
//            per-turn timeout that hands the turn to the other player.
// Revision : 1.0
// ============================================================================
module battleship_game_ctrl
    import battleship_pkg::*;
#(
    parameter int MAX_SHIPS      = c_DEFAULT_MAX_SHIPS,
    parameter int TIMEOUT_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       confirm,
    input  logic [2:0] amount_sel,
    input  logic       p1_place_done,
    input  logic       p2_place_done,
    input  logic       shot_valid,
    input  logic       shot_hit,
    input  logic [2:0] p1_ships_left,
    input  logic [2:0] p2_ships_left,
    output logic [2:0] state_o,
    output logic       place_en_p1,
    output logic       place_en_p2,
    output logic [2:0] ship_limit,
    output logic       active_player,
    output logic       fire_en,
    output logic [1:0] winner,
    output logic       timeout_pulse
);

    localparam logic [2:0] c_MAX_SHIPS = 3'(MAX_SHIPS);

    state_t     r_state;
    state_t     w_next;
    state_t     w_other_turn;
    logic       w_start_rise;
    logic       w_confirm_rise;
    logic       w_in_turn;
    logic       w_timeout;

    logic [2:0] r_ship_limit;
    logic [1:0] r_winner;
    logic       r_place_en_p1;
    logic       r_place_en_p2;
    logic       r_fire_en;
    logic       r_active_player;

    logic [2:0] w_ship_limit;
    logic [1:0] w_winner;
    logic       w_place_en_p1;
    logic       w_place_en_p2;
    logic       w_fire_en;
    logic       w_active_player;

    btn_edge_detect u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (start),
        .rise (w_start_rise)
    );

    btn_edge_detect u_confirm_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (confirm),
        .rise (w_confirm_rise)
    );

    assign w_in_turn    = (r_state == TURN_P1) || (r_state == TURN_P2);
    assign w_other_turn = (r_state == TURN_P1) ? TURN_P2 : TURN_P1;

`ifdef TURN_TIMEOUT_EN
    localparam int               c_TIMER_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_timeout_pulse;
    logic                 w_pulse;

    assign w_timeout = w_in_turn && (r_timer == c_TIMER_LAST);
    // A shot or a game-ending condition in the same cycle pre-empts the timeout.
    assign w_pulse   = w_timeout && !shot_valid && (w_next != GAME_OVER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer         <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_pulse;
            if ((w_next != r_state) || shot_valid || !w_in_turn) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_ship_limit    <= 3'd0;
            r_winner        <= c_WIN_NONE;
            r_place_en_p1   <= 1'b0;
            r_place_en_p2   <= 1'b0;
            r_fire_en       <= 1'b0;
            r_active_player <= c_PLAYER_P1;
        end else begin
            r_state         <= w_next;
            r_ship_limit    <= w_ship_limit;
            r_winner        <= w_winner;
            r_place_en_p1   <= w_place_en_p1;
            r_place_en_p2   <= w_place_en_p2;
            r_fire_en       <= w_fire_en;
            r_active_player <= w_active_player;
        end
    end

    // Next-state logic; end-of-game outranks shots, shots outrank the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_rise) w_next = SET_AMOUNT;
            end
            SET_AMOUNT: begin
                if (w_confirm_rise) w_next = PLACE_P1;
            end
            PLACE_P1: begin
                if (p1_place_done) w_next = PLACE_P2;
            end
            PLACE_P2: begin
                if (p2_place_done) w_next = TURN_P1;
            end
            TURN_P1, TURN_P2: begin
                if ((p1_ships_left == 3'd0) || (p2_ships_left == 3'd0)) begin
                    w_next = GAME_OVER;
                end else if (shot_valid) begin
                    if (!shot_hit) w_next = w_other_turn;
                end else if (w_timeout) begin
                    w_next = w_other_turn;
                end
            end
            GAME_OVER: begin
                if (w_start_rise) w_next = SET_AMOUNT;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        w_ship_limit    = r_ship_limit;
        w_winner        = r_winner;
        w_place_en_p1   = (w_next == PLACE_P1);
        w_place_en_p2   = (w_next == PLACE_P2);
        w_fire_en       = (w_next == TURN_P1) || (w_next == TURN_P2);
        w_active_player = ((w_next == PLACE_P2) || (w_next == TURN_P2)) ? c_PLAYER_P2
                                                                        : c_PLAYER_P1;

        if ((r_state == SET_AMOUNT) && (w_next == PLACE_P1)) begin
            w_ship_limit = clamp_ships(amount_sel, c_MAX_SHIPS);
        end

        if (w_next == SET_AMOUNT) begin
            w_winner = c_WIN_NONE;
        end else if (w_in_turn && (w_next == GAME_OVER)) begin
            // The shooter wins if the opponent is sunk; otherwise the shooter lost.
            if (r_state == TURN_P1) begin
                w_winner = (p2_ships_left == 3'd0) ? c_WIN_P1 : c_WIN_P2;
            end else begin
                w_winner = (p1_ships_left == 3'd0) ? c_WIN_P2 : c_WIN_P1;
            end
        end
    end

    assign state_o       = r_state;
    assign ship_limit    = r_ship_limit;
    assign winner        = r_winner;
    assign place_en_p1   = r_place_en_p1;
    assign place_en_p2   = r_place_en_p2;
    assign fire_en       = r_fire_en;
    assign active_player = r_active_player;

endmodule
`default_nettype wire
